// File: rtl/mealy_non_overlap_101_pkg.sv
// Shared state encodings for the serial 1-0-1 detector FSM.
package mealy_non_overlap_101_pkg;

  // 2'd3 is never entered legitimately; it exists so recovery is explicit.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    S1     = 2'd1,
    S10    = 2'd2,
    UNUSED = 2'd3
  } det_state_t;

endpackage

// File: rtl/mealy_non_overlap_101.sv
// Mealy detector for the serial pattern 1-0-1, non-overlapping; out is a
// combinational flag valid before the clock edge that consumes the third bit.
module mealy_non_overlap_101
  import mealy_non_overlap_101_pkg::*;
(
  input  logic clk,
  input  logic R,
  input  logic in,
  output logic out
);

  det_state_t r_state;
  det_state_t w_next_state;

  always_ff @(posedge clk) begin
    if (R) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A match returns to IDLE so its last '1' cannot start the next match.
  always_comb begin
    w_next_state = IDLE;
    out          = 1'b0;
    case (r_state)
      IDLE: begin
        w_next_state = in ? S1 : IDLE;
      end
      S1: begin
        w_next_state = in ? S1 : S10;
      end
      S10: begin
        w_next_state = IDLE;
        out          = in & ~R;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mealy_non_overlap_101.sv
// Self-checking bench: directed sequences plus random bits with occasional
// resets, compared against a bit-history model of non-overlapping 101 search.
module tb_mealy_non_overlap_101;

  logic clk;
  logic R;
  logic in;
  logic out;

  int n_vectors;
  int n_miscompares;

  // Bits received since the last reset or the last match.
  bit hist[$];

  mealy_non_overlap_101 dut (
    .clk (clk),
    .R   (R),
    .in  (in),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic observed, input logic expected);
    n_vectors++;
    if (observed !== expected) begin
      n_miscompares++;
      $display("FAIL %s: got %b, want %b", tag, observed, expected);
    end
  endtask

  // Model: a detect is when the three newest bits since restart read 1,0,1.
  function automatic logic model_step(input logic r, input logic b);
    logic det;
    det = 1'b0;
    if (r) begin
      hist.delete();
    end else begin
      hist.push_back(b);
      if (hist.size() >= 3 &&
          hist[hist.size()-3] == 1'b1 &&
          hist[hist.size()-2] == 1'b0 &&
          hist[hist.size()-1] == 1'b1) begin
        det = 1'b1;
        hist.delete();
      end
    end
    return det;
  endfunction

  // Drive on the falling edge, sample just before the next rising edge.
  task automatic apply_bit(input string tag, input logic r, input logic b);
    logic exp_out;
    @(negedge clk);
    R  = r;
    in = b;
    #2;
    exp_out = model_step(r, b);
    check_eq(tag, out, exp_out);
  endtask

  task automatic apply_seq(input string tag, input logic [15:0] bits, input int len);
    for (int i = len - 1; i >= 0; i--) begin
      apply_bit($sformatf("%s[%0d]", tag, len - 1 - i), 1'b0, bits[i]);
    end
  endtask

  initial begin
    n_vectors     = 0;
    n_miscompares = 0;
    R  = 1'b1;
    in = 1'b1;

    apply_bit("reset0", 1'b1, 1'b1);
    apply_bit("reset1", 1'b1, 1'b1);

    apply_seq("basic",    16'b101,    3);
    apply_seq("nonovl",   16'b10101,  5);
    apply_seq("prefix",   16'b1101,   4);
    apply_seq("miss",     16'b100101, 6);
    apply_seq("twice",    16'b101101, 6);

    apply_seq("midrst_a", 16'b10, 2);
    apply_bit("midrst_r", 1'b1, 1'b1);
    apply_seq("midrst_b", 16'b01, 2);

    apply_bit("rst_x", 1'b1, 1'bx);
    apply_bit("rst_x2", 1'b1, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic r;
      r = ($urandom_range(0, 99) < 4);
      apply_bit($sformatf("rand[%0d]", i), r, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
